// File: rtl/pio_event_sequencer.sv
// Avalon-MM master that services an edge-capturing button PIO and turns its captured
// falling edges into valid/ready event words for the time-keeping logic.
module pio_event_sequencer #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] MASK_INIT   = WIDTH'(8'hFF),
    parameter bit               USE_IRQ     = 1'b1,
    parameter int unsigned      POLL_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             pio_irq,
    input  logic             cfg_mask_valid,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic             cfg_mask_ready,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [WIDTH-1:0] event_bits,
    output logic             busy,
    output logic [15:0]      svc_count
);

    localparam int unsigned      PollW    = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_CYCLES - 1);

    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrCap  = 2'd3;

    typedef enum logic [2:0] {
        StInitMask,
        StInitClr,
        StIdle,
        StCfgMask,
        StRdCap,
        StClrCap,
        StEmit
    } state_e;

    state_e           state_q, state_d;
    logic             rst_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic [15:0]      svc_q, svc_d;

    logic             trigger;
    logic [WIDTH-1:0] cap_now;
    logic             unused_in;

    assign unused_in = ^{avm_readdata, pio_irq};

    assign trigger = USE_IRQ ? pio_irq : (poll_q == PollLast);
    assign cap_now = avm_readdata[WIDTH-1:0] & mask_q;

    // rst_q holds the machine quiet for the cycle after reset so the bus shows idle values
    // while reset is applied and the INIT_MASK write lands on the first cycle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInitMask;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rst_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rst_q) begin
            unique case (state_q)
                StInitMask: state_d = StInitClr;
                StInitClr:  state_d = StIdle;
                StIdle: begin
                    if (cfg_mask_valid) begin
                        state_d = StCfgMask;
                    end else if (trigger) begin
                        state_d = StRdCap;
                    end
                end
                StCfgMask:  state_d = StIdle;
                StRdCap:    state_d = StClrCap;
                StClrCap:   state_d = (cap_now == '0) ? StIdle : StEmit;
                StEmit: begin
                    if (event_ready) begin
                        state_d = StIdle;
                    end
                end
                default:    state_d = StInitMask;
            endcase
        end
    end

    always_comb begin
        mask_d = mask_q;
        cap_d  = cap_q;
        poll_d = '0;
        svc_d  = svc_q;
        if (!rst_q) begin
            if (state_q == StIdle && cfg_mask_valid) begin
                mask_d = cfg_mask;
            end
            if (state_q == StClrCap) begin
                cap_d = cap_now;
            end
            // Poll counter only runs while parked in IDLE; any exit restarts the period.
            if (!USE_IRQ && state_q == StIdle && state_d == StIdle) begin
                poll_d = poll_q + PollW'(1);
            end
            if (state_q == StEmit && event_ready && svc_q != 16'hFFFF) begin
                svc_d = svc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= MASK_INIT;
            cap_q  <= '0;
            poll_q <= '0;
            svc_q  <= '0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
            poll_q <= poll_d;
            svc_q  <= svc_d;
        end
    end

    always_comb begin
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'd0;
        event_valid    = 1'b0;
        event_bits     = '0;
        cfg_mask_ready = 1'b0;
        busy           = 1'b1;
        if (!rst_q) begin
            unique case (state_q)
                StInitMask: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = AddrMask;
                    avm_writedata  = 32'(MASK_INIT);
                end
                StInitClr: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = AddrCap;
                end
                StIdle: begin
                    cfg_mask_ready = 1'b1;
                    busy           = 1'b0;
                end
                StCfgMask: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = AddrMask;
                    avm_writedata  = 32'(mask_q);
                end
                StRdCap: begin
                    avm_chipselect = 1'b1;
                    avm_address    = AddrCap;
                end
                StClrCap: begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = AddrCap;
                end
                StEmit: begin
                    event_valid = 1'b1;
                    event_bits  = cap_q;
                end
                default: ;
            endcase
        end
    end

    assign svc_count = svc_q;

endmodule

// File: tb/tb_pio_event_sequencer.sv
// Bench for pio_event_sequencer: behavioural button PIOs, directed vector table,
// randomized steps against an abstract pending-edge model, reset and poll-mode sequences.
module tb_pio_event_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // IRQ-mode DUT
    logic [1:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [31:0] avm_writedata, avm_readdata;
    logic        pio_irq;
    logic        cfg_mask_valid = 1'b0;
    logic [7:0]  cfg_mask = 8'h00;
    logic        cfg_mask_ready, event_valid, busy;
    logic        event_ready = 1'b1;
    logic [7:0]  event_bits;
    logic [15:0] svc_count;

    // Poll-mode DUT
    logic [1:0]  avm_address_p;
    logic        avm_chipselect_p, avm_write_n_p;
    logic [31:0] avm_writedata_p, avm_readdata_p;
    logic        pio_irq_p;
    logic        cfg_mask_valid_p = 1'b0;
    logic [7:0]  cfg_mask_p = 8'h00;
    logic        cfg_mask_ready_p, event_valid_p, busy_p;
    logic        event_ready_p = 1'b1;
    logic [7:0]  event_bits_p;
    logic [15:0] svc_count_p;

    pio_event_sequencer #(.WIDTH(8), .MASK_INIT(8'hFF), .USE_IRQ(1'b1), .POLL_CYCLES(1000)) u_irq (
        .clk(clk), .reset(reset),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .pio_irq(pio_irq),
        .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask), .cfg_mask_ready(cfg_mask_ready),
        .event_valid(event_valid), .event_ready(event_ready), .event_bits(event_bits),
        .busy(busy), .svc_count(svc_count)
    );

    pio_event_sequencer #(.WIDTH(8), .MASK_INIT(8'hFF), .USE_IRQ(1'b0), .POLL_CYCLES(16)) u_poll (
        .clk(clk), .reset(reset),
        .avm_address(avm_address_p), .avm_chipselect(avm_chipselect_p),
        .avm_write_n(avm_write_n_p), .avm_writedata(avm_writedata_p),
        .avm_readdata(avm_readdata_p), .pio_irq(pio_irq_p),
        .cfg_mask_valid(cfg_mask_valid_p), .cfg_mask(cfg_mask_p),
        .cfg_mask_ready(cfg_mask_ready_p), .event_valid(event_valid_p),
        .event_ready(event_ready_p), .event_bits(event_bits_p), .busy(busy_p),
        .svc_count(svc_count_p)
    );

    // Button PIO models: falling-edge capture, clear-on-write overrides capture, registered read.
    logic [7:0] in_port = 8'hFF, in_prev, pio_cap, pio_msk;
    logic [7:0] in_port_p = 8'hFF, in_prev_p, pio_cap_p, pio_msk_p;

    always_ff @(posedge clk) begin
        in_prev <= in_port;
        if (reset) begin
            pio_cap <= 8'h00; pio_msk <= 8'h00; avm_readdata <= 32'd0;
        end else begin
            case (avm_address)
                2'd0:    avm_readdata <= {24'd0, in_port};
                2'd2:    avm_readdata <= {24'd0, pio_msk};
                2'd3:    avm_readdata <= {24'd0, pio_cap};
                default: avm_readdata <= 32'd0;
            endcase
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) pio_cap <= 8'h00;
            else pio_cap <= pio_cap | (in_prev & ~in_port);
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_msk <= avm_writedata[7:0];
        end
    end
    assign pio_irq = |(pio_cap & pio_msk);

    always_ff @(posedge clk) begin
        in_prev_p <= in_port_p;
        if (reset) begin
            pio_cap_p <= 8'h00; pio_msk_p <= 8'h00; avm_readdata_p <= 32'd0;
        end else begin
            case (avm_address_p)
                2'd0:    avm_readdata_p <= {24'd0, in_port_p};
                2'd2:    avm_readdata_p <= {24'd0, pio_msk_p};
                2'd3:    avm_readdata_p <= {24'd0, pio_cap_p};
                default: avm_readdata_p <= 32'd0;
            endcase
            if (avm_chipselect_p && !avm_write_n_p && avm_address_p == 2'd3) pio_cap_p <= 8'h00;
            else pio_cap_p <= pio_cap_p | (in_prev_p & ~in_port_p);
            if (avm_chipselect_p && !avm_write_n_p && avm_address_p == 2'd2)
                pio_msk_p <= avm_writedata_p[7:0];
        end
    end
    assign pio_irq_p = |(pio_cap_p & pio_msk_p);

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         cfg;
        logic [7:0] mask;
        logic [7:0] edges;
        int         stall;
        logic [7:0] late;
        bit         ev;
        logic [7:0] bits;
        bit         lat;
        bit         ev2;
        logic [7:0] bits2;
        int         svc;
    } vec_t;

    // Abstract model: set of captured-but-unread edges, current mask, serviced count.
    logic [7:0] m_mask;
    logic [7:0] m_pend;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [7:0] bits);
        in_port = ~bits;
        tick();
        in_port = 8'hFF;
    endtask

    task automatic wait_event(input int limit, output int n);
        n = 0;
        while (!event_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic check_bus(input string name, input logic cs, input logic wn,
                             input logic [1:0] addr, input logic [31:0] wd);
        check({name, " bus"}, 32'({avm_chipselect, avm_write_n, avm_address}), 32'({cs, wn, addr}));
        check({name, " data"}, avm_writedata, wd);
    endtask

    task automatic reset_seq(input int cycles, input string name);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        check({name, " rst bus"}, 32'({avm_chipselect, avm_write_n, avm_address}), 32'h4);
        check({name, " rst wdata"}, avm_writedata, 32'd0);
        check({name, " rst ev"}, 32'({event_valid, event_bits, cfg_mask_ready, busy}), 32'h001);
        check({name, " rst svc"}, 32'(svc_count), 32'd0);
        reset = 1'b0;
        tick();
        check_bus({name, " init mask"}, 1'b1, 1'b0, 2'd2, 32'h0000_00FF);
        tick();
        check_bus({name, " init clr"}, 1'b1, 1'b0, 2'd3, 32'd0);
        tick();
        check({name, " idle"}, 32'({cfg_mask_ready, busy}), 32'h2);
    endtask

    task automatic do_cfg(input logic [7:0] mask);
        int n = 0;
        cfg_mask = mask;
        cfg_mask_valid = 1'b1;
        while (!cfg_mask_ready && n < 20) begin
            tick();
            n++;
        end
        check("cfg ready", 32'(cfg_mask_ready), 32'd1);
        tick();
        cfg_mask_valid = 1'b0;
        check_bus("cfg write", 1'b1, 1'b0, 2'd2, {24'd0, mask});
        tick();
    endtask

    task automatic step(input vec_t v, input string tag);
        int n;
        int k;
        bit seen;
        event_ready = (v.stall == 0);
        if (v.cfg) do_cfg(v.mask);
        if (v.edges != 8'h00) inject(v.edges);
        if (v.ev) begin
            if (v.lat) begin
                tick();
                check_bus({tag, " rd cap"}, 1'b1, 1'b1, 2'd3, 32'd0);
                tick();
                check_bus({tag, " clr cap"}, 1'b1, 1'b0, 2'd3, 32'd0);
                tick();
                check({tag, " irq gone"}, 32'(pio_irq), 32'd0);
            end else begin
                wait_event(12, n);
            end
            check({tag, " valid"}, 32'(event_valid), 32'd1);
            check({tag, " bits"}, 32'(event_bits), 32'(v.bits));
            if (v.stall > 0) begin
                k = 0;
                if (v.late != 8'h00) begin
                    inject(v.late);
                    k = 1;
                end
                for (int i = k; i < v.stall; i++) tick();
                check({tag, " hold"}, 32'({event_valid, event_bits}), 32'({1'b1, v.bits}));
                event_ready = 1'b1;
            end
            tick();
            check({tag, " valid drop"}, 32'(event_valid), 32'd0);
            if (v.ev2) begin
                wait_event(12, n);
                check({tag, " valid2"}, 32'(event_valid), 32'd1);
                check({tag, " bits2"}, 32'(event_bits), 32'(v.bits2));
                tick();
                check({tag, " valid2 drop"}, 32'(event_valid), 32'd0);
            end
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (event_valid) seen = 1'b1;
            end
            check({tag, " no event"}, 32'(seen), 32'd0);
        end
        check({tag, " svc"}, 32'(svc_count), 32'(v.svc));
    endtask

    function automatic vec_t model_vec(input bit cfg, input logic [7:0] mask,
                                       input logic [7:0] edges, input int stall,
                                       input logic [7:0] late);
        vec_t v;
        v = '{cfg: cfg, mask: mask, edges: 8'h00, stall: stall, late: 8'h00, ev: 1'b0,
              bits: 8'h00, lat: 1'b0, ev2: 1'b0, bits2: 8'h00, svc: 0};
        if (cfg) m_mask = mask;
        if ((m_pend & m_mask) != 8'h00) begin
            // A mask change exposed edges captured earlier: serviced with no new stimulus.
            v.ev = 1'b1; v.bits = m_pend & m_mask; m_pend = 8'h00;
        end else begin
            v.edges = edges;
            m_pend = m_pend | edges;
            if ((m_pend & m_mask) != 8'h00) begin
                v.ev = 1'b1; v.lat = 1'b1; v.bits = m_pend & m_mask; m_pend = 8'h00;
            end
        end
        if (v.ev && stall > 0) begin
            v.late = late;
            m_pend = m_pend | late;
            if ((m_pend & m_mask) != 8'h00) begin
                v.ev2 = 1'b1; v.bits2 = m_pend & m_mask; m_pend = 8'h00;
            end
        end
        m_cnt = m_cnt + int'(v.ev) + int'(v.ev2);
        v.svc = m_cnt;
        return v;
    endfunction

    task automatic wait_rd_p(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(avm_chipselect_p && avm_write_n_p && avm_address_p == 2'd3) && n < 40);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        int   n;

        //          cfg   mask   edges  stl late   ev    bits   lat   ev2   bits2  svc
        vecs[0] = '{1'b0, 8'h00, 8'h04, 0,  8'h00, 1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1};
        vecs[1] = '{1'b1, 8'h01, 8'h00, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        vecs[2] = '{1'b0, 8'h00, 8'h08, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        vecs[3] = '{1'b0, 8'h00, 8'h01, 0,  8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 2};
        vecs[4] = '{1'b1, 8'hFF, 8'h00, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2};
        vecs[5] = '{1'b0, 8'h00, 8'h02, 10, 8'h20, 1'b1, 8'h02, 1'b1, 1'b1, 8'h20, 4};
        vecs[6] = '{1'b0, 8'h00, 8'h81, 3,  8'h00, 1'b1, 8'h81, 1'b1, 1'b0, 8'h00, 5};
        vecs[7] = '{1'b1, 8'hF0, 8'h0C, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5};
        vecs[8] = '{1'b1, 8'h0F, 8'h00, 0,  8'h00, 1'b1, 8'h0C, 1'b0, 1'b0, 8'h00, 6};
        vecs[9] = '{1'b1, 8'hFF, 8'hFF, 2,  8'h80, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h80, 8};

        reset_seq(3, "reset");
        for (int i = 0; i < 10; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Randomized steps; model state picks up where the table leaves it.
        m_mask = 8'hFF;
        m_pend = 8'h00;
        m_cnt  = 8;
        for (int r = 0; r < 40; r++) begin
            v = model_vec(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom) & 8'($urandom),
                          int'($urandom_range(0, 4)), 8'($urandom) & 8'($urandom));
            step(v, $sformatf("rand%0d", r));
        end
        v = model_vec(1'b1, 8'hFF, 8'h00, 0, 8'h00);
        step(v, "unmask");

        // Reset while an event is pending on the output.
        event_ready = 1'b0;
        inject(8'h10);
        wait_event(12, n);
        check("pre-reset valid", 32'({event_valid, event_bits}), 32'h110);
        reset_seq(1, "mid-emit");
        event_ready = 1'b1;

        // Poll mode: 16 idle cycles plus read and clear gives an 18-cycle period.
        wait_rd_p(n);
        check("poll first rd", 32'(n < 40), 32'd1);
        wait_rd_p(n);
        check("poll period a", 32'(n), 32'd18);
        wait_rd_p(n);
        check("poll period b", 32'(n), 32'd18);
        check("poll no event", 32'({event_valid_p, svc_count_p}), 32'd0);
        tick();
        tick();
        in_port_p = 8'hEF;
        tick();
        in_port_p = 8'hFF;
        n = 0;
        while (!event_valid_p && n < 25) begin
            tick();
            n++;
        end
        check("poll event", 32'({event_valid_p, event_bits_p}), 32'h110);
        tick();
        check("poll svc", 32'(svc_count_p), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
